// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg
// Shared constants and helpers for the arcade input glue.
//   - JOY_*   : bit positions inside a MiSTer joystick word
//   - SYS_*   : bit positions inside the active-low system byte
//   - clog2   : elaboration-time ceiling log2
//   - map_player : joystick word -> active-low arcade player byte
package arcade_input_pkg;

    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_FIRE1 = 5;
    localparam int JOY_FIRE2 = 6;
    localparam int JOY_FIRE3 = 7;
    localparam int JOY_START = 8;
    localparam int JOY_COIN  = 9;
    localparam int JOY_AUTO  = 10;

    localparam int SYS_COIN1   = 0;
    localparam int SYS_COIN2   = 1;
    localparam int SYS_START1  = 2;
    localparam int SYS_START2  = 3;
    localparam int SYS_SERVICE = 4;

    // Smallest r with 2**r >= value; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Arcade player byte: fire buttons on top, bit 6 unused (idle high).
    function automatic logic [7:0] map_player(input logic [15:0] j);
        return {~j[JOY_FIRE1], 1'b1, ~j[JOY_FIRE2], ~j[JOY_FIRE3],
                ~j[JOY_RIGHT], ~j[JOY_LEFT], ~j[JOY_DOWN], ~j[JOY_UP]};
    endfunction

endpackage

// File: rtl/arcade_input_mux_stretch.sv
// input_pulse_stretch
// Rising-edge detector feeding a frame counter. A press loads LEN, each
// frame tick counts down, pulse_n is low while the count is non-zero.
// Ports:
//   clk_sys, reset : clock, synchronous active-high reset
//   btn            : button level (active high)
//   tick           : one-cycle frame tick
//   retrig         : force a reload of LEN (used by autofire)
//   clear          : force the count to zero (lower priority than a load)
//   pulse_n        : registered active-low stretched pulse
//   load           : count loaded this cycle
//   expire         : count reaches zero on this tick
// LEN = 0 turns the block into a registered inverter of btn.
module input_pulse_stretch
    import arcade_input_pkg::*;
#(
    parameter int LEN = 4
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic btn,
    input  logic tick,
    input  logic retrig,
    input  logic clear,
    output logic pulse_n,
    output logic load,
    output logic expire
);

    localparam int CW = (clog2(LEN + 1) < 1) ? 1 : clog2(LEN + 1);

    generate
        if (LEN == 0) begin : g_pass
            logic pulse_n_r;
            logic unused_s;

            // Pass-through: button mirrored with one register stage.
            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    pulse_n_r <= 1'b1;
                end else begin
                    pulse_n_r <= ~btn;
                end
            end

            assign pulse_n  = pulse_n_r;
            assign load     = 1'b0;
            assign expire   = 1'b0;
            assign unused_s = &{1'b0, tick, retrig, clear};
        end else begin : g_count
            logic          btn_q_r;
            logic          pulse_n_r;
            logic [CW-1:0] cnt_r;
            logic [CW-1:0] cnt_next_s;
            logic          rise_s;
            logic          expire_s;
            logic          load_s;

            assign rise_s   = btn & ~btn_q_r;
            assign expire_s = tick && (cnt_r == CW'(1));
            // A press only counts once the previous pulse is over; a press on
            // the very tick that ends the pulse starts a fresh one.
            assign load_s   = (rise_s && ((cnt_r == {CW{1'b0}}) || expire_s)) || retrig;

            // Next count: load beats clear beats countdown.
            always_comb begin
                cnt_next_s = cnt_r;
                if (load_s) begin
                    cnt_next_s = CW'(LEN);
                end else if (clear) begin
                    cnt_next_s = {CW{1'b0}};
                end else if (tick && (cnt_r != {CW{1'b0}})) begin
                    cnt_next_s = cnt_r - CW'(1);
                end else begin
                    cnt_next_s = cnt_r;
                end
            end

            // Counter, edge history and registered pulse output.
            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    cnt_r     <= {CW{1'b0}};
                    btn_q_r   <= 1'b0;
                    pulse_n_r <= 1'b1;
                end else begin
                    cnt_r     <= cnt_next_s;
                    btn_q_r   <= btn;
                    pulse_n_r <= (cnt_next_s == {CW{1'b0}});
                end
            end

            assign pulse_n = pulse_n_r;
            assign load    = load_s;
            assign expire  = expire_s;
        end
    endgenerate

endmodule

// File: rtl/arcade_input_mux.sv
// arcade_input_mux
// Glue between hps_io and an arcade core: joystick words -> active-low
// player bytes, coin/start/service -> active-low system byte, and a DIP
// switch bank loaded through the ioctl download channel.
// Ports:
//   clk_sys, reset            : clock, synchronous active-high reset
//   ioctl_wr/index/addr/dout  : download channel (DIP bytes on DSW_INDEX)
//   vs                        : vertical sync, rising edge = frame tick
//   joy                       : NUM_PLAYERS joystick words, 16 bits each
//   service                   : service button, active high
//   players_n                 : registered active-low player bytes
//   system_n                  : registered active-low system byte
//   dsw_n                     : inverted DIP bank
// Optional build macro AUTOFIRE_EN: joy[10] turns fire1 into a square wave
// with a half-period of AUTOFIRE_FRAMES frames.
module arcade_input_mux
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int DSW_BYTES       = 8,
    parameter int DSW_INDEX       = 254,
    parameter int COIN_FRAMES     = 4,
    parameter int AUTOFIRE_FRAMES = 3
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     ioctl_wr,
    input  logic [7:0]               ioctl_index,
    input  logic [26:0]              ioctl_addr,
    input  logic [15:0]              ioctl_dout,
    input  logic                     vs,
    input  logic [16*NUM_PLAYERS-1:0] joy,
    input  logic                     service,
    output logic [8*NUM_PLAYERS-1:0] players_n,
    output logic [7:0]               system_n,
    output logic [8*DSW_BYTES-1:0]   dsw_n
);

    localparam logic [7:0] DSW_INDEX_B = 8'(DSW_INDEX);

    logic                       vs_q_r;
    logic                       tick_s;
    logic [8*NUM_PLAYERS-1:0]   players_next_s;
    logic [8*NUM_PLAYERS-1:0]   players_n_r;
    logic [5:0]                 sys_hi_r;
    logic                       coin1_n_s;
    logic                       coin2_n_s;
    logic                       start2_s;
    logic                       coin1_load_unused_s;
    logic                       coin1_expire_unused_s;
    // DIP switches power up cleared and deliberately ignore reset.
    logic [8*DSW_BYTES-1:0]     sw_r = {(8*DSW_BYTES){1'b0}};
    logic                       unused_s;

    // Frame timebase: remember last vs level.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vs_q_r <= 1'b0;
        end else begin
            vs_q_r <= vs;
        end
    end

    assign tick_s = vs & ~vs_q_r;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [15:0] joy_word_s;
        assign joy_word_s = joy[16*p +: 16];
`ifdef AUTOFIRE_EN
        logic       held_s;
        logic       af_load_s;
        logic       af_expire_s;
        logic       af_pulse_unused_s;
        logic       flag_r;
        logic       flag_next_s;
        logic [7:0] byte_s;

        assign held_s = joy_word_s[JOY_AUTO];

        // The stretcher doubles as the autofire frame counter: it reloads on
        // press and on every expiry while held, and is cleared on release.
        input_pulse_stretch #(.LEN(AUTOFIRE_FRAMES)) u_autofire (
            .clk_sys (clk_sys),
            .reset   (reset),
            .btn     (held_s),
            .tick    (tick_s),
            .retrig  (af_expire_s & held_s),
            .clear   (~held_s),
            .pulse_n (af_pulse_unused_s),
            .load    (af_load_s),
            .expire  (af_expire_s)
        );

        // Autofire flag: pressed on the first frame, inverted on each expiry.
        always_comb begin
            flag_next_s = flag_r;
            if (!held_s) begin
                flag_next_s = 1'b0;
            end else if (af_expire_s) begin
                flag_next_s = ~flag_r;
            end else if (af_load_s) begin
                flag_next_s = 1'b1;
            end else begin
                flag_next_s = flag_r;
            end
        end

        // Autofire flag register.
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                flag_r <= 1'b0;
            end else begin
                flag_r <= flag_next_s;
            end
        end

        // Player byte with fire1 replaced by the flag while autofire is held.
        always_comb begin
            byte_s = map_player(joy_word_s);
            if (held_s) begin
                byte_s[7] = ~flag_next_s;
            end else begin
                byte_s[7] = ~joy_word_s[JOY_FIRE1];
            end
        end

        assign players_next_s[8*p +: 8] = byte_s;
`else
        assign players_next_s[8*p +: 8] = map_player(joy_word_s);
`endif
    end

    // Player bytes, one cycle behind the joystick.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            players_n_r <= {NUM_PLAYERS{8'hFF}};
        end else begin
            players_n_r <= players_next_s;
        end
    end

    input_pulse_stretch #(.LEN(COIN_FRAMES)) u_coin1 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .btn     (joy[JOY_COIN]),
        .tick    (tick_s),
        .retrig  (1'b0),
        .clear   (1'b0),
        .pulse_n (coin1_n_s),
        .load    (coin1_load_unused_s),
        .expire  (coin1_expire_unused_s)
    );

    if (NUM_PLAYERS >= 2) begin : g_p2
        logic coin2_load_unused_s;
        logic coin2_expire_unused_s;

        assign start2_s = joy[16 + JOY_START];

        input_pulse_stretch #(.LEN(COIN_FRAMES)) u_coin2 (
            .clk_sys (clk_sys),
            .reset   (reset),
            .btn     (joy[16 + JOY_COIN]),
            .tick    (tick_s),
            .retrig  (1'b0),
            .clear   (1'b0),
            .pulse_n (coin2_n_s),
            .load    (coin2_load_unused_s),
            .expire  (coin2_expire_unused_s)
        );
    end else begin : g_p1
        assign start2_s  = 1'b0;
        assign coin2_n_s = 1'b1;
    end

    // Upper system bits (service, starts, fixed ones); coins come registered
    // from the stretchers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sys_hi_r <= 6'h3F;
        end else begin
            sys_hi_r <= {3'b111, ~service, ~start2_s, ~joy[JOY_START]};
        end
    end

    // DIP bank download; out-of-range addresses fall through untouched.
    always_ff @(posedge clk_sys) begin
        if (ioctl_wr && (ioctl_index == DSW_INDEX_B)) begin
            for (int k = 0; k < DSW_BYTES; k++) begin
                if (ioctl_addr == 27'(k)) begin
                    sw_r[8*k +: 8] <= ioctl_dout[7:0];
                end
            end
        end
    end

    assign players_n = players_n_r;
    assign system_n  = {sys_hi_r[5:3], sys_hi_r[SYS_SERVICE-2], sys_hi_r[SYS_START2-2],
                        sys_hi_r[SYS_START1-2], coin2_n_s, coin1_n_s};
    assign dsw_n     = ~sw_r;
    assign unused_s  = &{1'b0, ioctl_dout[15:8], joy, SYS_COIN1[0], SYS_COIN2[0]};

endmodule

// File: tb/tb_arcade_input_mux.sv
// Directed bench for arcade_input_mux: a default-parameter instance and a
// single-player, COIN_FRAMES=0 instance sharing clock, reset, vs and ioctl.
module tb_arcade_input_mux;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic [26:0] ioctl_addr = 27'd0;
    logic [15:0] ioctl_dout = 16'd0;
    logic        vs = 1'b0;
    logic [15:0] joy0 = 16'hFFFF;
    logic [15:0] joy1 = 16'hFFFF;
    logic [15:0] joy_b = 16'h0021;
    logic        service = 1'b0;

    logic [31:0] joy;
    logic [15:0] players_n;
    logic [7:0]  system_n;
    logic [63:0] dsw_n;
    logic [7:0]  players_n_b;
    logic [7:0]  system_n_b;
    logic [63:0] dsw_n_b;

    int checks   = 0;
    int failures = 0;

    assign joy = {joy1, joy0};

    always #5 clk_sys = ~clk_sys;

    arcade_input_mux dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ioctl_wr    (ioctl_wr),
        .ioctl_index (ioctl_index),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .vs          (vs),
        .joy         (joy),
        .service     (service),
        .players_n   (players_n),
        .system_n    (system_n),
        .dsw_n       (dsw_n)
    );

    arcade_input_mux #(.NUM_PLAYERS(1), .COIN_FRAMES(0)) dut_b (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ioctl_wr    (ioctl_wr),
        .ioctl_index (ioctl_index),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .vs          (vs),
        .joy         (joy_b),
        .service     (service),
        .players_n   (players_n_b),
        .system_n    (system_n_b),
        .dsw_n       (dsw_n_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // One frame: vs rises (tick on the first edge), then falls.
    task automatic frame();
        vs = 1'b1;
        step();
        vs = 1'b0;
        step();
    endtask

    task automatic dsw_write(input logic [7:0] idx, input logic [26:0] addr, input logic [15:0] data);
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = data;
        ioctl_wr    = 1'b1;
        step();
        ioctl_wr    = 1'b0;
        step();
    endtask

    initial begin
        // Reset with everything pressed: outputs idle high.
        step();
        chk("rst_players", {48'd0, players_n}, 64'h0000_0000_0000_FFFF);
        chk("rst_system", {56'd0, system_n}, 64'h0000_0000_0000_00FF);
        chk("rst_players_b", {56'd0, players_n_b}, 64'h0000_0000_0000_00FF);
        chk("rst_dsw", dsw_n, 64'hFFFF_FFFF_FFFF_FFFF);

        // First cycle after reset: right + fire1.
        reset = 1'b0;
        joy0  = 16'h0021;
        joy1  = 16'h0000;
        step();
        chk("map_right_fire1", {48'd0, players_n}, 64'h0000_0000_0000_FF77);
        chk("sys_idle", {56'd0, system_n}, 64'h0000_0000_0000_00FF);
        chk("map_b", {56'd0, players_n_b}, 64'h0000_0000_0000_0077);

        // Fire buttons on player 0, directions on player 1.
        joy0 = 16'h00E0;
        joy1 = 16'h000F;
        step();
        chk("map_fire_dirs", {48'd0, players_n}, 64'h0000_0000_0000_F04F);

        // Starts and service.
        joy0 = 16'h0100;
        joy1 = 16'h0100;
        service = 1'b1;
        step();
        chk("sys_start_service", {56'd0, system_n}, 64'h0000_0000_0000_00E3);
        joy0 = 16'h0000;
        joy1 = 16'h0000;
        service = 1'b0;
        step();

        // DIP download; wrong index and out-of-range address are dropped.
        dsw_write(8'd254, 27'd0, 16'hBE3C);
        dsw_write(8'd254, 27'd1, 16'h00A5);
        dsw_write(8'd254, 27'd8, 16'h0011);
        dsw_write(8'd253, 27'd2, 16'h0077);
        chk("dsw_load", dsw_n, 64'hFFFF_FFFF_FFFF_5AC3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("dsw_after_reset", dsw_n, 64'hFFFF_FFFF_FFFF_5AC3);

        // Coin 1 pulse, with an ignored re-press during the pulse.
        joy0 = 16'h0200;
        step();
        chk("coin_press", {56'd0, system_n}, 64'h0000_0000_0000_00FE);
        joy0 = 16'h0000;
        step();
        frame();
        frame();
        frame();
        chk("coin_hold3", {56'd0, system_n}, 64'h0000_0000_0000_00FE);
        joy0 = 16'h0200;
        step();
        joy0 = 16'h0000;
        step();
        chk("coin_repress", {56'd0, system_n}, 64'h0000_0000_0000_00FE);
        frame();
        chk("coin_end", {56'd0, system_n}, 64'h0000_0000_0000_00FF);

        // Press coincident with the tick that would end the pulse reloads it.
        joy0 = 16'h0200;
        step();
        joy0 = 16'h0000;
        step();
        frame();
        frame();
        frame();
        vs   = 1'b1;
        joy0 = 16'h0200;
        step();
        chk("coin_coinc_reload", {56'd0, system_n}, 64'h0000_0000_0000_00FE);
        vs   = 1'b0;
        joy0 = 16'h0000;
        step();
        frame();
        frame();
        frame();
        chk("coin_coinc_hold", {56'd0, system_n}, 64'h0000_0000_0000_00FE);
        frame();
        chk("coin_coinc_end", {56'd0, system_n}, 64'h0000_0000_0000_00FF);

        // Coin 2, then reset mid-pulse.
        joy1 = 16'h0200;
        step();
        chk("coin2_press", {56'd0, system_n}, 64'h0000_0000_0000_00FD);
        joy1  = 16'h0000;
        reset = 1'b1;
        step();
        chk("coin2_reset", {56'd0, system_n}, 64'h0000_0000_0000_00FF);
        reset = 1'b0;
        step();
        chk("coin2_cleared", {56'd0, system_n}, 64'h0000_0000_0000_00FF);

        // COIN_FRAMES=0 single-player instance: registered pass-through.
        joy_b = 16'h0200;
        #1;
        chk("b_coin_latency", {56'd0, system_n_b}, 64'h0000_0000_0000_00FF);
        step();
        chk("b_coin_press", {56'd0, system_n_b}, 64'h0000_0000_0000_00FE);
        joy_b = 16'h0000;
        step();
        chk("b_coin_release", {56'd0, system_n_b}, 64'h0000_0000_0000_00FF);

`ifdef AUTOFIRE_EN
        // Autofire: low 3 frames, high 3, low again; release restores fire1.
        joy0 = 16'h0400;
        step();
        chk("af_press", {56'd0, players_n[7:0]}, 64'h0000_0000_0000_007F);
        frame();
        frame();
        chk("af_low2", {56'd0, players_n[7:0]}, 64'h0000_0000_0000_007F);
        frame();
        chk("af_high", {56'd0, players_n[7:0]}, 64'h0000_0000_0000_00FF);
        frame();
        frame();
        chk("af_high2", {56'd0, players_n[7:0]}, 64'h0000_0000_0000_00FF);
        frame();
        chk("af_low_again", {56'd0, players_n[7:0]}, 64'h0000_0000_0000_007F);
        joy0 = 16'h0000;
        step();
        chk("af_release", {56'd0, players_n[7:0]}, 64'h0000_0000_0000_00FF);
`else
        // Without autofire, joy[10] has no effect.
        joy0 = 16'h0400;
        step();
        chk("af_off_press", {56'd0, players_n[7:0]}, 64'h0000_0000_0000_00FF);
        frame();
        frame();
        frame();
        chk("af_off_frames", {56'd0, players_n[7:0]}, 64'h0000_0000_0000_00FF);
        joy0 = 16'h0020;
        step();
        chk("af_off_fire1", {56'd0, players_n[7:0]}, 64'h0000_0000_0000_007F);
        joy0 = 16'h0000;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
